// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command parser: parser state encoding,
// the default sync marker and a saturating 16-bit increment.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    EMIT = 3'd5
  } parser_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer for one command frame: single write port, combinational read.
// Contents are not reset; only bytes written in the current frame are ever read.
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the RX FIFO byte stream (SYNC ADDR LEN DATA[LEN] CHK) into register write beats.
// Optional inter-byte timeout is compiled in when CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic        rx_err,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [15:0] frame_ok,
  output logic [15:0] frame_err
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // Write beat handshake: a beat transfers on every cycle where wr_valid && wr_ready;
  // while wr_valid is high and wr_ready low, wr_addr/wr_data hold their values.

  parser_state_e state_q, state_d;
  logic          run_q;
  logic          rd_pending_q;
  logic          rx_err_q;
  logic [7:0]    addr_q, len_q, chk_q, idx_q;
  logic [15:0]   frame_ok_q, frame_err_q;
  logic [7:0]    buf_rdata;

  logic byte_vld, rx_err_rise, in_frame, tmo_hit;
  logic latch_addr, chk_upd, latch_len, buf_we, idx_clr, idx_inc, ok_inc, err_evt;

  // fifo_dout is valid the cycle after the strobe, so a pending read marks a consumed byte
  assign byte_vld    = rd_pending_q;
  assign rx_err_rise = rx_err & ~rx_err_q;
  assign in_frame    = (state_q == ADDR) || (state_q == LEN) ||
                       (state_q == DATA) || (state_q == CHK);
  assign fifo_rd_en  = run_q && (state_q != EMIT) && !fifo_empty && !rd_pending_q;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit = in_frame && !byte_vld && (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_cnt_q <= '0;
    else if (!in_frame || byte_vld) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    chk_upd    = 1'b0;
    latch_len  = 1'b0;
    buf_we     = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    ok_inc     = 1'b0;
    err_evt    = 1'b0;
    case (state_q)
      IDLE: if (byte_vld && fifo_dout == SYNC_BYTE) state_d = ADDR;
      ADDR: if (byte_vld) begin
        latch_addr = 1'b1;
        state_d    = LEN;
      end
      LEN: if (byte_vld) begin
        if (fifo_dout == 8'd0 || fifo_dout > MAX_LEN_B) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else begin
          latch_len = 1'b1;
          chk_upd   = 1'b1;
          idx_clr   = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: if (byte_vld) begin
        buf_we  = 1'b1;
        chk_upd = 1'b1;
        if (idx_q == len_q - 8'd1) state_d = CHK;
        else                       idx_inc = 1'b1;
      end
      CHK: if (byte_vld) begin
        if (fifo_dout == chk_q) begin
          idx_clr = 1'b1;
          state_d = EMIT;
        end else begin
          err_evt = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: if (wr_ready) begin
        if (idx_q == len_q - 8'd1) begin
          ok_inc  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame that already passed CHK is not aborted by a receiver error
    if (rx_err_rise || tmo_hit) begin
      err_evt = 1'b1;
      if (in_frame) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      rd_pending_q <= 1'b0;
      rx_err_q     <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      idx_q        <= '0;
      frame_ok_q   <= '0;
      frame_err_q  <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      rd_pending_q <= fifo_rd_en;
      rx_err_q     <= rx_err;
      if (latch_addr) begin
        addr_q <= fifo_dout;
        chk_q  <= fifo_dout;
      end else if (chk_upd) begin
        chk_q <= chk_q ^ fifo_dout;
      end
      if (latch_len) len_q <= fifo_dout;
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + 8'd1;
      if (ok_inc)  frame_ok_q  <= sat_inc16(frame_ok_q);
      if (err_evt) frame_err_q <= sat_inc16(frame_err_q);
    end
  end

  uart_cmd_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (fifo_dout),
    .raddr (idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign wr_valid  = (state_q == EMIT);
  assign wr_addr   = wr_valid ? (addr_q + idx_q) : 8'd0;
  assign wr_data   = wr_valid ? buf_rdata : 8'd0;
  assign busy      = (state_q != IDLE);
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

endmodule
